mod_n_digit_counter: RTL and testbench
======================================

MOD_N_DIGIT_COUNTER -- requirements
Module: mod_n_digit_counter

Interface
REQ-001 Parameter WIDTH, default 4: bit width of count, load and compare values.
REQ-002 Parameter MODULUS, default 10: count range 0..MODULUS-1; legal 2 <= MODULUS <= 2^WIDTH.
REQ-003 Clk  input  1: clock, all state changes on rising edge except reset.
REQ-004 Clr  input  1: reset, asynchronous, active-low.
REQ-005 Enable  input  1: block enable; gates load and count.
REQ-006 LD  input  1: synchronous load request, active-high.
REQ-007 IN  input  WIDTH: load value.
REQ-008 Up  input  1: direction; 1 = up, 0 = down.
REQ-009 Cin  input  1: cascade count request (tie 1 for a standalone digit).
REQ-010 CMP  input  WIDTH: compare value for alarm match.
REQ-011 COUNT  output  WIDTH: current count, registered.
REQ-012 Cout  output  1: combinational carry/borrow to next digit.
REQ-013 WRAP  output  1: registered one-cycle pulse, count wrapped.
REQ-014 MATCH  output  1: registered, COUNT equals CMP.
REQ-015 LD_ERR  output  1: registered one-cycle pulse, out-of-range load clamped.

Function
REQ-016 Priority per rising edge: Clr low > (LD & Enable) > (Cin & Enable) count > hold.
REQ-017 Load: IN <= MODULUS-1 -> COUNT = IN next cycle; IN >= MODULUS -> COUNT = MODULUS-1 and LD_ERR = 1 for that one cycle.
REQ-018 Load is synchronous only; LD never acts asynchronously and never acts while Enable = 0.
REQ-019 Count up (Up = 1): COUNT + 1; at MODULUS-1 wraps to 0.
REQ-020 Count down (Up = 0): COUNT - 1; at 0 wraps to MODULUS-1.
REQ-021 Arithmetic is modulo MODULUS; COUNT never holds a value >= MODULUS after reset.
REQ-022 Cout = Enable & Cin & ~LD & (Up ? COUNT == MODULUS-1 : COUNT == 0); combinational, same cycle as the wrapping edge.
REQ-023 WRAP = 1 for exactly the one cycle following an edge on which a count wrapped; a load never asserts WRAP.
REQ-024 Simultaneous LD and Cin with Enable: load wins, no count, Cout = 0, WRAP = 0.
REQ-025 Up may change on any cycle; direction sampled on the counting edge only.
REQ-026 MATCH is registered from next-state COUNT and CMP, so MATCH is valid in the same cycle as the new COUNT; it is level, not pulse.
REQ-027 Enable = 0: COUNT holds; Cout = 0; WRAP and LD_ERR deassert next cycle; MATCH keeps tracking CMP.
REQ-028 LD_ERR and WRAP never assert together.

Reset
REQ-029 Clr low asynchronously forces COUNT = 0, WRAP = 0, LD_ERR = 0, MATCH = (CMP == 0) on the first edge after release; MATCH = 0 while Clr low.
REQ-030 Clr asserted mid-count or mid-load aborts the operation; no WRAP or LD_ERR pulse is produced.
REQ-031 After Clr release, the first rising edge performs normal operation; no extra latency cycle.
REQ-032 Power-up state before any Clr equals the reset state.

Verification
REQ-033 MODULUS=10, Up=1, Cin=1, Enable=1, 12 edges from 0 -> 1..9,0,1,2; Cout high while COUNT=9; WRAP high the cycle COUNT=0.
REQ-034 Up=0 from COUNT=1, two edges -> 0 then 9; Cout high while COUNT=0; WRAP pulse once.
REQ-035 LD=1, IN=12, MODULUS=10 -> COUNT=9, LD_ERR one-cycle pulse; IN=5 -> COUNT=5, no LD_ERR.
REQ-036 COUNT=9, LD=1, Cin=1, IN=3 same edge -> COUNT=3, Cout=0, WRAP=0.
REQ-037 Clr pulsed low between edges at COUNT=7 -> COUNT=0 immediately, no WRAP; counting resumes 1 on next edge.
REQ-038 Two instances cascaded (MODULUS=10 units, MODULUS=6 tens, units Cout -> tens Cin), 60 edges from 00 -> 59 then 00; CMP=4 on tens -> MATCH high exactly while tens COUNT=4.

Source files
------------

// File: rtl/mod_n_digit_counter.sv
// Single modulo-N counter digit with load clamp, wrap pulse and compare match.
// Digits cascade by feeding one digit's Cout into the next digit's Cin.
module mod_n_digit_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Enable,
  input  logic             LD,
  input  logic [WIDTH-1:0] IN,
  input  logic             Up,
  input  logic             Cin,
  input  logic [WIDTH-1:0] CMP,
  output logic [WIDTH-1:0] COUNT,
  output logic             Cout,
  output logic             WRAP,
  output logic             MATCH,
  output logic             LD_ERR
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic             ld_err_reg;
  logic             ld_err_next;
  logic             match_reg;
  logic             do_load;
  logic             do_count;
  logic             at_limit;

  assign do_load  = Enable & LD;
  assign do_count = Enable & Cin & ~LD;
  assign at_limit = Up ? (count_reg == MAX_VAL) : (count_reg == '0);

  always_comb begin
    count_next  = count_reg;
    wrap_next   = 1'b0;
    ld_err_next = 1'b0;
    if (do_load) begin
      if ({1'b0, IN} >= MOD_EXT) begin
        count_next  = MAX_VAL;
        ld_err_next = 1'b1;
      end else begin
        count_next = IN;
      end
    end else if (do_count) begin
      wrap_next = at_limit;
      if (Up) begin
        count_next = at_limit ? '0 : count_reg + WIDTH'(1);
      end else begin
        count_next = at_limit ? MAX_VAL : count_reg - WIDTH'(1);
      end
    end
  end

  // MATCH is taken from the next-state count so it lines up with the new COUNT.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      count_reg  <= '0;
      wrap_reg   <= 1'b0;
      ld_err_reg <= 1'b0;
      match_reg  <= 1'b0;
    end else begin
      count_reg  <= count_next;
      wrap_reg   <= wrap_next;
      ld_err_reg <= ld_err_next;
      match_reg  <= (count_next == CMP);
    end
  end

  assign COUNT  = count_reg;
  assign Cout   = do_count & at_limit;
  assign WRAP   = wrap_reg;
  assign LD_ERR = ld_err_reg;
  assign MATCH  = match_reg;

endmodule

// File: tb/tb_mod_n_digit_counter.sv
// Scoreboard bench for mod_n_digit_counter: a units digit (MOD 10) drives
// a tens digit (MOD 6) through Cout -> Cin.
module tb_mod_n_digit_counter;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       enable = 1'b0;
  logic       ld = 1'b0;
  logic [3:0] in_val = 4'd0;
  logic       up = 1'b1;
  logic       cin = 1'b0;
  logic [3:0] cmp = 4'd0;
  logic [3:0] count;
  logic       cout;
  logic       wrap;
  logic       match;
  logic       ld_err;

  logic       tens_ld = 1'b0;
  logic [3:0] tens_in = 4'd0;
  logic [3:0] tens_cmp = 4'd4;
  logic [3:0] tens_count;
  logic       tens_cout;
  logic       tens_wrap;
  logic       tens_match;
  logic       tens_ld_err;

  int checks = 0;
  int failures = 0;

  // Expected state after an edge: {COUNT, WRAP, LD_ERR, MATCH}
  logic [6:0] sb[$];
  logic [4:0] tens_sb[$];
  logic [3:0] m_count = 4'd0;
  logic       exp_cout;
  logic [6:0] e;
  logic [4:0] te;

  always #5 clk = ~clk;

  mod_n_digit_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .Clk(clk), .Clr(clr), .Enable(enable), .LD(ld), .IN(in_val), .Up(up),
    .Cin(cin), .CMP(cmp), .COUNT(count), .Cout(cout), .WRAP(wrap),
    .MATCH(match), .LD_ERR(ld_err)
  );

  mod_n_digit_counter #(.WIDTH(4), .MODULUS(6)) tens (
    .Clk(clk), .Clr(clr), .Enable(enable), .LD(tens_ld), .IN(tens_in), .Up(up),
    .Cin(cout), .CMP(tens_cmp), .COUNT(tens_count), .Cout(tens_cout),
    .WRAP(tens_wrap), .MATCH(tens_match), .LD_ERR(tens_ld_err)
  );

  // Apply inputs for the coming edge and push the modelled outcome.
  task automatic drive(input logic en_i, input logic ld_i, input logic [3:0] in_i,
                       input logic up_i, input logic cin_i, input logic [3:0] cmp_i);
    logic [3:0] nxt;
    logic       w;
    logic       le;
    enable = en_i; ld = ld_i; in_val = in_i; up = up_i; cin = cin_i; cmp = cmp_i;
    nxt = m_count; w = 1'b0; le = 1'b0;
    exp_cout = 1'b0;
    if (en_i && ld_i) begin
      if (in_i >= 4'd10) begin nxt = 4'd9; le = 1'b1; end
      else nxt = in_i;
    end else if (en_i && cin_i) begin
      if (up_i) begin
        w = (m_count == 4'd9);
        nxt = w ? 4'd0 : m_count + 4'd1;
      end else begin
        w = (m_count == 4'd0);
        nxt = w ? 4'd9 : m_count - 4'd1;
      end
      exp_cout = w;
    end
    sb.push_back({nxt, w, le, (nxt == cmp_i)});
    m_count = nxt;
  endtask

  task automatic test_reset();
    clr = 1'b0; cmp = 4'd0; enable = 1'b1; cin = 1'b1; ld = 1'b1; in_val = 4'd5;
    @(posedge clk); #1; @(posedge clk); #1;
    checks++;
    if ({count, wrap, ld_err, match} !== 7'b0000_000) begin
      failures++; $display("FAIL reset_hold: got %b expected %b", {count, wrap, ld_err, match}, 7'b0);
    end
    clr = 1'b1; m_count = 4'd0;
    drive(0, 0, 0, 1, 1, 0);
    @(posedge clk); #1; e = sb.pop_front(); checks++;
    if ({count, wrap, ld_err, match} !== e) begin
      failures++; $display("FAIL reset_first_edge: got %b expected %b", {count, wrap, ld_err, match}, e);
    end
    drive(1, 0, 0, 1, 1, 0);
    @(posedge clk); #1; e = sb.pop_front(); checks++;
    if ({count, wrap, ld_err, match} !== e || count !== 4'd1) begin
      failures++; $display("FAIL reset_no_latency: got %b expected %b", {count, wrap, ld_err, match}, e);
    end
  endtask

  task automatic test_count_up();
    drive(1, 1, 0, 1, 1, 15);
    @(posedge clk); #1; e = sb.pop_front(); checks++;
    if ({count, wrap, ld_err, match} !== e) begin
      failures++; $display("FAIL up_load0: got %b expected %b", {count, wrap, ld_err, match}, e);
    end
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 0, 1, 1, 15);
      #1; checks++;
      if (cout !== exp_cout) begin
        failures++; $display("FAIL up_cout[%0d]: got %b expected %b", i, cout, exp_cout);
      end
      @(posedge clk); #1; e = sb.pop_front(); checks++;
      if ({count, wrap, ld_err, match} !== e) begin
        failures++; $display("FAIL up_step[%0d]: got %b expected %b", i, {count, wrap, ld_err, match}, e);
      end
    end
    checks++;
    if (count !== 4'd2) begin
      failures++; $display("FAIL up_final: got %0d expected 2", count);
    end
  endtask

  task automatic test_count_down();
    drive(1, 1, 1, 0, 0, 9);
    @(posedge clk); #1; e = sb.pop_front(); checks++;
    if ({count, wrap, ld_err, match} !== e) begin
      failures++; $display("FAIL down_load1: got %b expected %b", {count, wrap, ld_err, match}, e);
    end
    for (int i = 0; i < 5; i++) begin
      // two plain down edges, then Up toggles each edge
      drive(1, 0, 0, (i < 2) ? 1'b0 : logic'(i[0]), 1, 9);
      #1; checks++;
      if (cout !== exp_cout) begin
        failures++; $display("FAIL down_cout[%0d]: got %b expected %b", i, cout, exp_cout);
      end
      @(posedge clk); #1; e = sb.pop_front(); checks++;
      if ({count, wrap, ld_err, match} !== e) begin
        failures++; $display("FAIL down_step[%0d]: got %b expected %b", i, {count, wrap, ld_err, match}, e);
      end
    end
  endtask

  task automatic test_load();
    logic [3:0] vals[5] = '{4'd12, 4'd5, 4'd15, 4'd9, 4'd3};
    for (int i = 0; i < 5; i++) begin
      // last entry: LD with Enable low must not load
      drive((i == 4) ? 1'b0 : 1'b1, 1, vals[i], 1, 0, 5);
      @(posedge clk); #1; e = sb.pop_front(); checks++;
      if ({count, wrap, ld_err, match} !== e) begin
        failures++; $display("FAIL load[%0d]: got %b expected %b", i, {count, wrap, ld_err, match}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 9, 1, 0, 3);
    @(posedge clk); #1; e = sb.pop_front(); checks++;
    if ({count, wrap, ld_err, match} !== e) begin
      failures++; $display("FAIL b2b_load9: got %b expected %b", {count, wrap, ld_err, match}, e);
    end
    drive(1, 1, 3, 1, 1, 3);
    #1; checks++;
    if (cout !== 1'b0) begin
      failures++; $display("FAIL b2b_cout: got %b expected 0", cout);
    end
    @(posedge clk); #1; e = sb.pop_front(); checks++;
    if ({count, wrap, ld_err, match} !== e) begin
      failures++; $display("FAIL b2b_load_wins: got %b expected %b", {count, wrap, ld_err, match}, e);
    end
  endtask

  task automatic test_enable_off();
    logic [3:0] cmps[3] = '{4'd3, 4'd4, 4'd3};
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, (i == 0) ? 1'b0 : 1'b1, 1, cmps[i]);
      #1; checks++;
      if (cout !== 1'b0) begin
        failures++; $display("FAIL en_off_cout[%0d]: got %b expected 0", i, cout);
      end
      @(posedge clk); #1; e = sb.pop_front(); checks++;
      if ({count, wrap, ld_err, match} !== e) begin
        failures++; $display("FAIL en_off[%0d]: got %b expected %b", i, {count, wrap, ld_err, match}, e);
      end
    end
  endtask

  task automatic test_async_clear();
    drive(1, 1, 7, 1, 0, 0);
    @(posedge clk); #1; e = sb.pop_front(); checks++;
    if ({count, wrap, ld_err, match} !== e) begin
      failures++; $display("FAIL clr_load7: got %b expected %b", {count, wrap, ld_err, match}, e);
    end
    #2 clr = 1'b0;
    #1 checks++;
    if ({count, wrap, ld_err, match} !== 7'b0) begin
      failures++; $display("FAIL clr_async: got %b expected %b", {count, wrap, ld_err, match}, 7'b0);
    end
    clr = 1'b1; m_count = 4'd0;
    drive(1, 0, 0, 1, 1, 15);
    @(posedge clk); #1; e = sb.pop_front(); checks++;
    if ({count, wrap, ld_err, match} !== e || count !== 4'd1) begin
      failures++; $display("FAIL clr_resume: got %b expected %b", {count, wrap, ld_err, match}, e);
    end
    drive(1, 1, 9, 1, 0, 15);
    @(posedge clk); #1; e = sb.pop_front(); checks++;
    if ({count, wrap, ld_err, match} !== e) begin
      failures++; $display("FAIL clr_load9: got %b expected %b", {count, wrap, ld_err, match}, e);
    end
    // wrapping count and clamped load both aborted by Clr held across the edge
    enable = 1'b1; ld = 1'b0; cin = 1'b1; up = 1'b1; cmp = 4'd0;
    clr = 1'b0;
    @(posedge clk); #1; checks++;
    if ({count, wrap, ld_err, match} !== 7'b0) begin
      failures++; $display("FAIL clr_abort_wrap: got %b expected %b", {count, wrap, ld_err, match}, 7'b0);
    end
    ld = 1'b1; in_val = 4'd14;
    @(posedge clk); #1; checks++;
    if ({count, wrap, ld_err, match} !== 7'b0) begin
      failures++; $display("FAIL clr_abort_load: got %b expected %b", {count, wrap, ld_err, match}, 7'b0);
    end
    clr = 1'b1; m_count = 4'd0;
  endtask

  task automatic test_cascade();
    int n;
    clr = 1'b0; #2 clr = 1'b1; m_count = 4'd0;
    tens_cmp = 4'd4;
    for (int k = 0; k < 60; k++) begin
      drive(1, 0, 0, 1, 1, 15);
      n = (k + 1) % 60;
      tens_sb.push_back({4'(n / 10), (n / 10) == 4});
      @(posedge clk); #1;
      e = sb.pop_front(); te = tens_sb.pop_front(); checks++;
      if ({count, wrap, ld_err, match} !== e || {tens_count, tens_match} !== te) begin
        failures++; $display("FAIL cascade[%0d]: got units %b tens %b expected units %b tens %b",
                             k, {count, wrap, ld_err, match}, {tens_count, tens_match}, e, te);
      end
    end
    checks++;
    if (count !== 4'd0 || tens_count !== 4'd0) begin
      failures++; $display("FAIL cascade_final: got %0d%0d expected 00", tens_count, count);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_back_to_back();
    test_enable_off();
    test_async_clear();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
